imm_gen_stage: RTL

- Pipelined, parametrised immediate generator for the decode stage.
- Decodes the RISC-V format directly from the opcode; no external control code.
- Produces the sign-extended XLEN immediate (I/S/B/U/J) and the PC-relative target for B and J.
- Sits between fetch and execute behind a valid/ready handshake with a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.

---
 rtl/imm_gen_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imm_gen_stage                                                     |
// | Desc   : RISC-V immediate/branch-target decode stage with 2-entry skid     |
// |          buffer. Optional CSR-immediate (Z) format via IMM_GEN_CSR_EN.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [PC_W-1:0] o_target,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc
);

    localparam logic [2:0] C_FMT_NONE = 3'd0;
    localparam logic [2:0] C_FMT_I    = 3'd1;
    localparam logic [2:0] C_FMT_S    = 3'd2;
    localparam logic [2:0] C_FMT_B    = 3'd3;
    localparam logic [2:0] C_FMT_U    = 3'd4;
    localparam logic [2:0] C_FMT_J    = 3'd5;
    localparam logic [2:0] C_FMT_Z    = 3'd6;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [PC_W-1:0] target;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_t      r_state, w_state_nxt;
    entry_t      r_m, r_k, w_new;
    logic        r_rdy_en;
    logic [31:0] w_imm32;
    logic [2:0]  w_fmt;
    logic        w_accept, w_drain, w_load_m, w_load_k, w_k_to_m;

    // Every format fits a signed 32-bit value; widening to XLEN is one sign-extend.
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = C_FMT_NONE;
        case (i_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_fmt   = C_FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            7'b0100011: begin
                w_fmt   = C_FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = C_FMT_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = C_FMT_U;
                w_imm32 = {i_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                w_fmt   = C_FMT_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
`ifdef IMM_GEN_CSR_EN
            7'b1110011: begin
                if (i_instr[14]) begin
                    w_fmt   = C_FMT_Z;
                    w_imm32 = {27'd0, i_instr[19:15]};
                end else begin
                    w_fmt   = C_FMT_I;
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
`else
            7'b1110011: begin
                w_fmt   = C_FMT_NONE;
                w_imm32 = 32'd0;
            end
`endif
            default: begin
                w_fmt   = C_FMT_NONE;
                w_imm32 = 32'd0;
            end
        endcase
    end

    // NONE carries imm 0, so pc + imm already yields pc; only Z must bypass the add.
    always_comb begin
        w_new.imm    = XLEN'($signed(w_imm32));
        w_new.fmt    = w_fmt;
        w_new.target = (w_fmt == C_FMT_Z) ? i_pc : i_pc + PC_W'($signed(w_imm32));
        w_new.instr  = i_instr;
        w_new.pc     = i_pc;
    end

    assign w_accept = i_valid & o_ready;
    assign w_drain  = o_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_m    = 1'b0;
        w_load_k    = 1'b0;
        w_k_to_m    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_m    = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_m = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_k    = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_drain) begin
                    w_state_nxt = S_ONE;
                    w_k_to_m    = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = S_EMPTY;
            w_load_m    = 1'b0;
            w_load_k    = 1'b0;
            w_k_to_m    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_EMPTY;
            r_m      <= '0;
            r_k      <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
            if (w_load_m) begin
                r_m <= w_new;
            end else if (w_k_to_m) begin
                r_m <= r_k;
            end
            if (w_load_k) begin
                r_k <= w_new;
            end
        end
    end

    // Ready stays low through reset and rises on the first edge after release.
    assign o_ready  = r_rdy_en & (r_state != S_FULL);
    assign o_valid  = (r_state != S_EMPTY);
    assign o_imm    = r_m.imm;
    assign o_fmt    = r_m.fmt;
    assign o_target = r_m.target;
    assign o_instr  = r_m.instr;
    assign o_pc     = r_m.pc;

endmodule
`default_nettype wire
